// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative multiply sequencer:
// state encoding, MulCtrl codes and operand width.
package core_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_WB_LO,
    S_WB_HI
  } mul_state_e;

  localparam logic [3:0] MUL_32  = 4'b0000;
  localparam logic [3:0] MULS_32 = 4'b0001;
  localparam logic [3:0] UMULL   = 4'b0100;
  localparam logic [3:0] UMULLS  = 4'b0101;
  localparam logic [3:0] SMULL   = 4'b0110;
  localparam logic [3:0] SMULLS  = 4'b0111;

  function automatic logic mul_ctrl_valid(input logic [3:0] c);
    return (c == MUL_32) || (c == MULS_32) ||
           (c == UMULL)  || (c == UMULLS)  ||
           (c == SMULL)  || (c == SMULLS);
  endfunction

  function automatic logic mul_ctrl_signed(input logic [3:0] c);
    return c[3:1] == 3'b011;
  endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Request/write-back bundle between the main core FSM
// and the multiply sequencer.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       MulCtrl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Flush;
  logic             Busy;
  logic             LoValid;
  logic             HiValid;
  logic [WIDTH-1:0] Result;
  logic             Done;
  logic             FlagValid;
  logic [1:0]       NZ;

  modport master (
    output Start, MulCtrl, SrcA, SrcB, Flush,
    input  Busy, LoValid, HiValid, Result,
    input  Done, FlagValid, NZ
  );

  modport slave (
    input  Start, MulCtrl, SrcA, SrcB, Flush,
    output Busy, LoValid, HiValid, Result,
    output Done, FlagValid, NZ
  );
endinterface

// File: rtl/mul_sequencer_shift_add_dp.sv
// Shift-add datapath: operand registers, WIDTH+1 adder,
// product shifter and final two's-complement negate.
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               negate,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [2*WIDTH-1:0] prod
);

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] stepped;
  logic [2*WIDTH-1:0] prod_n;

  // -2^(W-1) maps to 2^(W-1) when viewed unsigned, so it stays exact
  assign a_abs = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign b_abs = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  assign sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
               (mplier_q[0] ? {1'b0, mcand_q} : '0);

  assign stepped = {sum, prod_q[WIDTH-1:1]};
  assign prod_n  = negate ? -stepped : stepped;
  assign prod    = prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (load) begin
      mcand_q  <= a_abs;
      mplier_q <= b_abs;
      prod_q   <= '0;
    end else if (step) begin
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_n;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Iterative radix-2 multiply unit with write-back sequencing
// of low/high result words and optional N/Z flags.
module mul_sequencer
  import core_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           reset,
  mul_sequencer_if.slave bus
);

  mul_state_e         state;
  logic [CNT_W-1:0]   cnt;
  logic               long_q;
  logic               flags_q;
  logic               neg_q;
  logic               busy_q;
  logic               lo_q;
  logic               hi_q;
  logic               done_q;
  logic               fv_q;
  logic [1:0]         nz_q;
  logic               load;
  logic               step;
  logic               last;
  logic               n_now;
  logic               z_now;
  logic [2*WIDTH-1:0] prod;

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign load = (state == S_IDLE) && bus.Start && !bus.Flush &&
                mul_ctrl_valid(bus.MulCtrl);
  assign step = (state == S_CALC) && !bus.Flush;

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst_n     (reset),
    .load      (load),
    .step      (step),
    .negate    (step && last && neg_q),
    .is_signed (mul_ctrl_signed(bus.MulCtrl)),
    .src_a     (bus.SrcA),
    .src_b     (bus.SrcB),
    .prod      (prod)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      long_q  <= 1'b0;
      flags_q <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      lo_q    <= 1'b0;
      hi_q    <= 1'b0;
      done_q  <= 1'b0;
      fv_q    <= 1'b0;
      nz_q    <= 2'b00;
    end else begin
      lo_q   <= 1'b0;
      hi_q   <= 1'b0;
      done_q <= 1'b0;
      fv_q   <= 1'b0;
      if (done_q) nz_q <= {n_now, z_now};
      if (bus.Flush) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (load) begin
              long_q  <= bus.MulCtrl[2];
              flags_q <= bus.MulCtrl[0];
              neg_q   <= mul_ctrl_signed(bus.MulCtrl) &
                         (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
              cnt     <= '0;
              busy_q  <= 1'b1;
              state   <= S_CALC;
            end
          end
          S_CALC: begin
            cnt <= cnt + 1'b1;
            if (last) begin
              state  <= S_WB_LO;
              lo_q   <= 1'b1;
              done_q <= !long_q;
              fv_q   <= !long_q && flags_q;
            end
          end
          S_WB_LO: begin
            if (long_q) begin
              state  <= S_WB_HI;
              hi_q   <= 1'b1;
              done_q <= 1'b1;
              fv_q   <= flags_q;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end
          S_WB_HI: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign n_now = long_q ? prod[2*WIDTH-1] : prod[WIDTH-1];
  assign z_now = long_q ? (prod == '0) : (prod[WIDTH-1:0] == '0);

  assign bus.Busy      = busy_q;
  assign bus.LoValid   = lo_q;
  assign bus.HiValid   = hi_q;
  assign bus.Done      = done_q;
  assign bus.FlagValid = fv_q;
  assign bus.NZ        = done_q ? {n_now, z_now} : nz_q;
  assign bus.Result    = lo_q ? prod[WIDTH-1:0] :
                         hi_q ? prod[2*WIDTH-1:WIDTH] : '0;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed vector bench for mul_sequencer: table-driven ops
// plus busy-start, flush and mid-operation reset sequences.
module tb_mul_sequencer;
  import core_pkg::*;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        lng;
    logic        fv;
    logic [1:0]  nz;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mul_sequencer_if #(.WIDTH(32)) bus ();

  mul_sequencer u_dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    bus.Start   = 1'b1;
    bus.MulCtrl = c;
    bus.SrcA    = a;
    bus.SrcB    = b;
  endtask

  // Full operation: Start driven in cycle 0, checks at 32..35
  task automatic run_op(input vec_t v);
    @(negedge clk);
    issue(v.ctrl, v.a, v.b);
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1) bus.Start = 1'b0;
      if (c == 1) chk("busy_c1", bus.Busy, 1);
      if (c == 32) chk("lo_early", bus.LoValid, 0);
      if (c == 33) begin
        chk("lo_valid", bus.LoValid, 1);
        chk("lo_result", bus.Result, v.lo);
        chk("lo_done", bus.Done, !v.lng);
        chk("lo_hi", bus.HiValid, 0);
        if (!v.lng) chk("lo_fv", bus.FlagValid, v.fv);
        if (!v.lng && v.fv) chk("lo_nz", bus.NZ, v.nz);
      end
      if (c == 34) begin
        if (v.lng) begin
          chk("hi_valid", bus.HiValid, 1);
          chk("hi_result", bus.Result, v.hi);
          chk("hi_done", bus.Done, 1);
          chk("hi_fv", bus.FlagValid, v.fv);
          if (v.fv) chk("hi_nz", bus.NZ, v.nz);
        end else begin
          chk("idle_34", bus.Busy, 0);
        end
      end
      if (c == 35) begin
        chk("idle_35", bus.Busy, 0);
        if (v.fv) chk("nz_hold", bus.NZ, v.nz);
      end
    end
  endtask

  vec_t vecs[10];
  int   hits;

  initial begin
    tests = 0;
    fails = 0;
    bus.Start   = 1'b0;
    bus.Flush   = 1'b0;
    bus.MulCtrl = 4'b0000;
    bus.SrcA    = '0;
    bus.SrcB    = '0;
    rst = 1'b0;

    vecs[0] = '{MUL_32, 32'd7, 32'd6, 32'd42, 32'd0, 0, 0, 2'b00};
    vecs[1] = '{UMULLS, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h00000001, 32'hFFFFFFFE, 1, 1, 2'b10};
    vecs[2] = '{SMULL, 32'hFFFFFFFE, 32'd3,
                32'hFFFFFFFA, 32'hFFFFFFFF, 1, 0, 2'b00};
    vecs[3] = '{SMULLS, 32'h80000000, 32'h80000000,
                32'h00000000, 32'h40000000, 1, 1, 2'b00};
    vecs[4] = '{MULS_32, 32'd0, 32'h1234, 32'd0, 32'd0, 0, 1, 2'b01};
    vecs[5] = '{MULS_32, 32'h80000000, 32'd1,
                32'h80000000, 32'd0, 0, 1, 2'b10};
    vecs[6] = '{UMULL, 32'h00010000, 32'h00010000,
                32'h00000000, 32'h00000001, 1, 0, 2'b00};
    vecs[7] = '{SMULLS, 32'd5, 32'hFFFFFFFF,
                32'hFFFFFFFB, 32'hFFFFFFFF, 1, 1, 2'b10};
    vecs[8] = '{MUL_32, 32'hFFFFFFFF, 32'd2,
                32'hFFFFFFFE, 32'd0, 0, 0, 2'b00};
    vecs[9] = '{SMULLS, 32'h80000000, 32'd1,
                32'h80000000, 32'hFFFFFFFF, 1, 1, 2'b10};

    #12;
    chk("rst_busy", bus.Busy, 0);
    chk("rst_lo", bus.LoValid, 0);
    chk("rst_hi", bus.HiValid, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_fv", bus.FlagValid, 0);
    chk("rst_nz", bus.NZ, 0);
    chk("rst_result", bus.Result, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Invalid MulCtrl is ignored
    @(negedge clk);
    issue(4'b0010, 32'd3, 32'd3);
    @(negedge clk);
    bus.Start = 1'b0;
    chk("invalid_ctrl", bus.Busy, 0);

    // Flush beats Start in IDLE
    @(negedge clk);
    issue(MUL_32, 32'd3, 32'd3);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    chk("flush_start", bus.Busy, 0);

    // Start while busy is ignored
    @(negedge clk);
    issue(MUL_32, 32'd100, 32'd3);
    hits = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 1) bus.Start = 1'b0;
      if (c == 10) issue(UMULL, 32'd9, 32'd9);
      if (c == 11) bus.Start = 1'b0;
      if (c == 33) begin
        chk("busy_start_lo", bus.Result, 300);
        chk("busy_start_done", bus.Done, 1);
      end
      if (c > 33 && (bus.HiValid || bus.Busy)) hits++;
    end
    chk("busy_start_quiet", hits, 0);

    // Flush mid-calc: no write-back at all
    @(negedge clk);
    issue(UMULL, 32'd11, 32'd13);
    hits = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) bus.Start = 1'b0;
      if (c == 15) bus.Flush = 1'b1;
      if (c == 16) begin
        bus.Flush = 1'b0;
        chk("flush_idle", bus.Busy, 0);
      end
      if (bus.LoValid || bus.HiValid || bus.Done) hits++;
    end
    chk("flush_no_wb", hits, 0);
    run_op('{MUL_32, 32'd3, 32'd5, 32'd15, 32'd0, 0, 0, 2'b00});

    // Reset mid-operation
    @(negedge clk);
    issue(UMULL, 32'hFFFF, 32'hFFFF);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bus.Start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_lo", bus.LoValid, 0);
    chk("mid_rst_done", bus.Done, 0);
    chk("mid_rst_result", bus.Result, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op('{MUL_32, 32'd3, 32'd5, 32'd15, 32'd0, 0, 0, 2'b00});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Iterative radix-2 shift-add multiply unit with its own control FSM, serving the multicycle core's MUL/MULS/UMULL(S)/SMULL(S) instructions. It replaces a single-cycle multiplier in the ALU path. The main FSM issues one request with Start. The block computes over 32 cycles, then sequences the write-back: RdLo first, then RdHi for long multiplies. Flag results for S-variants are returned with Done.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits
CNT_W, 5, iteration counter width, equal to clog2(WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
Start  input  1  request strobe; sampled only in IDLE
MulCtrl  input  4  operation, same encoding as ALUControl mul family: 0000 MUL, 0001 MULS, 0100 UMULL, 0101 UMULLS, 0110 SMULL, 0111 SMULLS
SrcA  input  WIDTH  multiplicand (Rn/Rm operand)
SrcB  input  WIDTH  multiplier
Flush  input  1  synchronous abort
Busy  output  1  high in any state except IDLE
LoValid  output  1  ResultLo valid; main FSM writes RdLo this cycle
HiValid  output  1  ResultHi valid; main FSM writes RdHi this cycle
Result  output  WIDTH  write-back data: low word in WB_LO, high word in WB_HI, else 0
Done  output  1  one-cycle pulse on the final write-back cycle
FlagValid  output  1  asserted with Done when MulCtrl[0] was 1
NZ  output  2  {N,Z} of the full result, meaningful when FlagValid

Behaviour:
- Reset (async, reset==0): state IDLE, counter 0, accumulators 0, all outputs 0.
- States: IDLE, CALC, WB_LO, WB_HI.
- IDLE handling of Start:
  - Start=1 with a valid MulCtrl: latch MulCtrl.
  - Signed ops (MulCtrl[3:1]==011): latch abs(SrcA) and abs(SrcB); neg = SrcA[31]^SrcB[31].
  - Unsigned and 32-bit ops: latch raw operands; neg=0.
  - Clear the product, set count=0, go to CALC.
  - Invalid MulCtrl: ignored, stay IDLE.
- CALC, one iteration per cycle:
  - If multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH product. Keep the carry in a WIDTH+1 adder.
  - Shift {carry, product} right by 1, shift the multiplier right by 1, increment count.
  - At the edge where count==WIDTH-1: finish the iteration. If neg, two's-complement the full 64-bit product. Go to WB_LO.
  - CALC always lasts exactly WIDTH cycles.
- WB_LO: LoValid=1, Result=product[31:0].
  - 32-bit ops (MulCtrl[2]==0): Done=1 here; next state IDLE.
  - Long ops: next state WB_HI.
- WB_HI: HiValid=1, Result=product[63:32], Done=1; next state IDLE.
- Latency: the Start cycle is cycle 0. WB_LO is cycle WIDTH+1 (33). WB_HI is cycle 34.
- Flags:
  - 32-bit ops: N=product[31], Z=(product[31:0]==0).
  - Long ops: N=product[63], Z=(product[63:0]==0).
  - Computed from the final (post-negate) product. FlagValid=Done&latched MulCtrl[0]. NZ holds its value until the next Done.
- Start while Busy: ignored, no queuing, operands not resampled. Start and Done in the same cycle: Start ignored; the core re-issues.
- Flush: from any state, next state IDLE, no further LoValid/HiValid/Done. Flush in WB_LO still lets that cycle's LoValid stand (already combinational), then aborts WB_HI. Flush in IDLE: no effect.
- Flush and Start in the same IDLE cycle: Flush wins; stay IDLE.
- Reset mid-operation: immediate return to IDLE, outputs 0, no Done.
- Boundary: SrcA=0x80000000 signed. abs is taken as an unsigned 32-bit value (0x80000000) so SMULL of -2^31 is exact.

Decomposition:
- Shared package (core_pkg): mul state enum, MulCtrl encodings (MUL_32, MULS_32, UMULL, UMULLS, SMULL, SMULLS), WIDTH default.
- One natural sub-module: mul_shift_add_dp. It holds the multiplicand, multiplier, product registers, adder, shifter and final negate, controlled by load/step/negate strobes from the FSM.

Test Plan:
- MUL, SrcA=7, SrcB=6 -> LoValid and Done in cycle 33, Result=42, no HiValid, FlagValid=0.
- UMULLS, SrcA=SrcB=0xFFFFFFFF -> cycle 33 Result=0x00000001; cycle 34 Result=0xFFFFFFFE with HiValid, Done, NZ=10.
- SMULL, SrcA=0xFFFFFFFE (-2), SrcB=3 -> Lo=0xFFFFFFFA, Hi=0xFFFFFFFF. SMULLS, SrcA=SrcB=0x80000000 -> Hi=0x40000000, Lo=0, NZ=00.
- MULS, SrcA=0, SrcB=0x1234 -> Result=0, FlagValid=1, NZ=01. MULS 0x80000000*1 -> NZ=10.
- Second Start issued at cycle 10 with different operands -> ignored, first result unchanged. Flush at cycle 15 -> IDLE at cycle 16, no Done. A new Start then completes normally.
- reset driven 0 at cycle 20 of a UMULL -> Busy=0 and all outputs 0 immediately. After release, a MUL 3*5 returns 15 at cycle 33.
